// File: rtl/resize_mul_arbiter.sv
// rtl/resize_mul_arbiter.sv - round-robin arbiter sharing one pipelined multiplier
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester operand handshake
//   req_a, req_b          packed operands, requester i at [i*DIN_WIDTH +: DIN_WIDTH]
//   rsp_valid/rsp_ready   one-hot product handshake, addressed to the originating requester
//   rsp_data              product shared by all requesters
//   mul_ce                clock enable to the external multiplier
//   mul_din0, mul_din1    operands to the external multiplier
//   mul_dout              external multiplier result (MUL_LATENCY ce-qualified stages)
//   busy                  any operation in flight
module resize_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DIN_WIDTH   = 12,
    parameter int DOUT_WIDTH  = 24,
    parameter int MUL_LATENCY = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DOUT_WIDTH-1:0]          rsp_data,
    output logic                           mul_ce,
    output logic [DIN_WIDTH-1:0]           mul_din0,
    output logic [DIN_WIDTH-1:0]           mul_din1,
    input  logic [DOUT_WIDTH-1:0]          mul_dout,
    output logic                           busy
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Tracking pipeline mirrors the multiplier stages: slot MUL_LATENCY-1 is the head.
    logic [MUL_LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]       tag_q [MUL_LATENCY];
    logic [TAG_W-1:0]       tag_d [MUL_LATENCY];
    logic [TAG_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                   head_vld;
    logic [TAG_W-1:0]       head_tag;
    logic                   grant_found;
    logic [TAG_W-1:0]       grant_idx;
    logic [DIN_WIDTH-1:0]   sel_a, sel_b;
    logic                   handshake;
    int                     cand;

    assign head_vld = vld_q[MUL_LATENCY-1];
    assign head_tag = tag_q[MUL_LATENCY-1];

    // Only the addressed requester's rsp_ready can stall; with no valid head the
    // pipeline keeps flowing, which also flushes stale multiplier data in reset.
    assign mul_ce   = ~(head_vld & ~rsp_ready[head_tag]);
    assign rsp_data = mul_dout;
    assign busy     = |vld_q;

    // Round-robin search: walk from the highest offset down so the candidate
    // closest to rr_ptr_q (lowest offset) is the one left standing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        cand        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[TAG_W-1:0];
                sel_a       = req_a[cand*DIN_WIDTH +: DIN_WIDTH];
                sel_b       = req_b[cand*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    // rst_n gates acceptance so nothing is granted while the state is held clear.
    assign handshake = rst_n & mul_ce & grant_found;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (head_vld) begin
            rsp_valid[head_tag] = 1'b1;
        end
        mul_din0 = handshake ? sel_a : '0;
        mul_din1 = handshake ? sel_b : '0;
    end

    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        if (mul_ce) begin
            vld_d[0] = handshake;
            tag_d[0] = handshake ? grant_idx : '0;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
            if (handshake) begin
                rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_resize_mul_arbiter.sv
// tb/tb_resize_mul_arbiter.sv - directed self-checking bench for resize_mul_arbiter
module tb_resize_mul_arbiter;

    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int OW  = 24;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [OW-1:0]     rsp_data;
    logic              mul_ce;
    logic [DW-1:0]     mul_din0;
    logic [DW-1:0]     mul_din1;
    logic [OW-1:0]     mul_dout;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_prod [N] = '{32'd15, 32'd60, 32'd135, 32'd240};
    logic [11:0] bnd_a [3]    = '{12'd0, 12'd1, 12'd2048};
    logic [11:0] bnd_b [3]    = '{12'd4095, 12'd4095, 12'd2};
    logic [31:0] bnd_p [3]    = '{32'd0, 32'd4095, 32'd4096};

    always #5 clk = ~clk;

    resize_mul_arbiter #(
        .NUM_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MUL_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .busy(busy)
    );

    // Behavioural multiplier: LAT clock-enabled register stages, no reset.
    logic [OW-1:0] mp [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= mul_din0 * mul_din1;
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_dout = mp[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    task automatic load_table_ops();
        for (int i = 0; i < N; i++) set_op(i, 12'((i + 1) * 3), 12'((i + 1) * 5));
    endtask

    initial begin
        int  waitc;
        logic got3;

        // Reset state, with requests pending to show they are refused
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        load_table_ops();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_ce", mul_ce, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        // Single request on requester 2, max operands
        @(negedge clk);
        set_op(2, 12'd4095, 12'd4095);
        req_valid = 4'b0100;
        #1;
        check("single_req_ready", req_ready, 4'b0100);
        check("single_din0", mul_din0, 4095);
        check("single_din1", mul_din1, 4095);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("single_c1_rsp_valid", rsp_valid, 0);
        check("single_c1_busy", busy, 1);
        @(negedge clk);
        #1;
        check("single_c2_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        check("single_c3_rsp_valid", rsp_valid, 4'b0100);
        check("single_c3_rsp_data", rsp_data, 32'd16769025);
        @(negedge clk);
        #1;
        check("single_drained_rsp_valid", rsp_valid, 0);
        check("single_drained_busy", busy, 0);

        // Round robin with all four requesters continuously valid
        do_reset();
        load_table_ops();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) check("rr_grant", req_ready, 32'd1 << (k % 4));
            if (k >= 3) begin
                check("rr_rsp_valid", rsp_valid, 32'd1 << ((k - 3) % 4));
                check("rr_rsp_data", rsp_data, exp_prod[(k - 3) % 4]);
            end
        end

        // Backpressure: head tag 1 refused for five cycles
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b1110;
            #1;
            check("bp_issue_grant", req_ready, 32'd1 << (k + 1));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            rsp_ready = 4'b1101;
            #1;
            check("bp_stall_ce", mul_ce, 0);
            check("bp_stall_req_ready", req_ready, 0);
            check("bp_stall_rsp_valid", rsp_valid, 4'b0010);
            check("bp_stall_rsp_data", rsp_data, 60);
        end
        @(negedge clk);
        rsp_ready = 4'b1111;
        #1;
        check("bp_release_ce", mul_ce, 1);
        check("bp_release_rsp_valid", rsp_valid, 4'b0010);
        check("bp_retire_issue_ready", req_ready, 4'b0001);
        check("bp_retire_issue_din0", mul_din0, 3);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("bp_after_valid2", rsp_valid, 4'b0100);
        check("bp_after_data2", rsp_data, 135);
        @(negedge clk);
        #1;
        check("bp_after_valid3", rsp_valid, 4'b1000);
        check("bp_after_data3", rsp_data, 240);
        @(negedge clk);
        #1;
        check("bp_after_valid0", rsp_valid, 4'b0001);
        check("bp_after_data0", rsp_data, 15);
        @(negedge clk);
        #1;
        check("bp_drained_busy", busy, 0);
        check("bp_drained_rsp_valid", rsp_valid, 0);

        // Fairness: requester 0 always valid, requester 3 asks once
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("fair_first_grant", req_ready, 4'b0001);
        got3  = 1'b0;
        waitc = 0;
        for (int k = 0; k < 4 && !got3; k++) begin
            @(negedge clk);
            req_valid = 4'b1001;
            #1;
            waitc++;
            if (req_ready[3]) got3 = 1'b1;
        end
        check("fair_req3_granted", got3, 1);
        check("fair_req3_wait", waitc, 1);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("fair_back_to_0", req_ready, 4'b0001);

        // Reset mid-flight with three operations in the pipeline
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b0111;
            #1;
            check("mid_issue_grant", req_ready, 32'd1 << k);
        end
        check("mid_busy_before", busy, 1);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("mid_after_rsp_valid", rsp_valid, 0);
            check("mid_after_busy", busy, 0);
        end
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        check("mid_next_grant_lowest", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;

        // Zero and boundary operands, back-to-back on requester 0
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 3) begin
                set_op(0, bnd_a[k], bnd_b[k]);
                req_valid = 4'b0001;
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 3) check("bnd_grant", req_ready, 4'b0001);
            if (k >= 3) begin
                check("bnd_rsp_valid", rsp_valid, 4'b0001);
                check("bnd_rsp_data", rsp_data, bnd_p[k - 3]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
